// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency imem and buffers {pc, inst} pairs for decode.
// Optional misaligned-redirect fault handling is compiled in with `define FETCH_MISALIGN_CHK_EN.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW:0]   used;
    logic          credit;
    logic          can_fetch;
    logic          push;
    logic          pop;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    logic halted;
    logic misaligned;
    logic fault_mem [DEPTH];

    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign can_fetch  = !halted;
`else
    assign can_fetch  = 1'b1;
`endif

    // The in-flight request already owns a slot, so the credit check makes overrun impossible.
    assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign credit    = (used < (CW+1)'(DEPTH));
    assign imem_req  = !rst && !redirect_valid && credit && can_fetch;
    assign imem_addr = pc;

    assign push     = inflight && !redirect_valid;
    assign id_valid = (count != '0) && !redirect_valid;
    assign pop      = id_valid && id_ready;

    assign id_pc   = (count != '0) ? pc_mem[rd_ptr]   : '0;
    assign id_inst = (count != '0) ? inst_mem[rd_ptr] : '0;
`ifdef FETCH_MISALIGN_CHK_EN
    assign id_fault = (count != '0) ? fault_mem[rd_ptr] : 1'b0;
`else
    assign id_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            halted   <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Flush everything younger, including a response arriving this cycle.
            inflight <= 1'b0;
            rd_ptr   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            pc       <= redirect_pc;
            halted   <= misaligned;
            count    <= misaligned ? CW'(1) : '0;
            wr_ptr   <= misaligned ? AW'(1) : '0;
`else
            pc       <= redirect_pc & ~32'h3;
            count    <= '0;
            wr_ptr   <= '0;
`endif
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // NOTE: the storage arrays are deliberately not reset; count gates every read, so stale contents never reach decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                pc_mem[wr_ptr]   <= req_pc;
                inst_mem[wr_ptr] <= imem_rdata;
`ifdef FETCH_MISALIGN_CHK_EN
                fault_mem[wr_ptr] <= 1'b0;
            end else if (redirect_valid && misaligned) begin
                pc_mem[0]    <= redirect_pc;
                inst_mem[0]  <= NOP_INST;
                fault_mem[0] <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage with a small prefetch FIFO, directly upstream of decode.
- Owns the PC, issues requests to a synchronous instruction memory with fixed 1-cycle latency, and buffers {pc, inst} pairs.
- Hands pairs to decode/immediate generation over a valid/ready handshake.
- Accepts redirects from the branch/jump resolution stage and flushes all younger fetched work.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  32  fetch address; equals the current PC.
- imem_rdata  input  32  instruction for the request issued in the previous cycle.
- redirect_valid  input  1  control-flow redirect.
- redirect_pc  input  32  redirect target.
- id_valid  output  1  FIFO head valid to decode.
- id_ready  input  1  decode accepts the head.
- id_pc  output  32  PC of the head entry.
- id_inst  output  32  instruction of the head entry.
- id_fault  output  1  head entry is a misaligned-fetch fault (feature only; otherwise tied 0).

Behaviour:
- Reset, while rst=1 at the edge:
  - pc=RESET_PC, count=0, rd/wr pointers=0, inflight=0.
  - Outputs read 0 in the cycle after reset: imem_req=0, id_valid=0, id_pc=0, id_inst=0, id_fault=0.
  - Reset mid-operation discards all FIFO contents and any in-flight response.
- Issue:
  - imem_req = !rst && !redirect_valid && (count + inflight < DEPTH).
  - The condition does not depend on id_ready, so there is no combinational ready-to-request path.
  - Each issue sets inflight<=1 and pc<=pc+4. The PC wraps modulo 2^32: 32'hFFFF_FFFC becomes 0.
  - A cycle without issue sets inflight<=0 and holds pc.
- Response:
  - If inflight=1 and no redirect this cycle, {pc_of_request, imem_rdata} is written at the FIFO tail at the edge.
  - pc_of_request is held in a register captured at issue.
- Output:
  - id_valid = (count != 0) && !redirect_valid.
  - id_pc and id_inst come from the head entry and are registered storage, not imem_rdata.
  - A pop occurs when id_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO full cannot be overrun, because the issue credit includes the in-flight request.
  - FIFO empty: id_valid=0; id_ready is ignored.
- Redirect, asserted in cycle R:
  - At the edge: count=0, pointers reset, inflight=0, pc<=redirect_pc.
  - Any response arriving in R is dropped; no pop occurs in R.
  - R+1: imem_req=1 with imem_addr=redirect_pc.
  - R+2: data written to the FIFO.
  - R+3: id_valid=1 with id_pc=redirect_pc.
  - Back-to-back redirects: the latest one wins.
  - Redirect with rst=1: reset wins.
- Throughput: with DEPTH>=4 and id_ready held 1, one instruction per cycle in steady state.
- id_ready=0 stall: the FIFO fills, then imem_req drops once count+inflight=DEPTH. Fetch resumes the cycle after the first pop frees credit.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets a halted flag and performs no imem request.
  - One fault entry is pushed in R+1: id_pc=redirect_pc, id_inst=32'h0000_0013 (NOP), id_fault=1.
  - While halted, imem_req=0. Only a later aligned redirect or rst clears halted.
  - id_fault=0 for all normal entries.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 on load.
  - No halted state; id_fault is tied 0.

Test Plan:
1. Reset with RESET_PC=32'h100, id_ready=1, memory returns addr^32'hA5A5_0000 -> first imem_req at 0x100; id_valid from cycle 3 after reset release; id_pc sequence 0x100, 0x104, 0x108 with matching id_inst; one entry per cycle.
2. id_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 requests issued, count=4, imem_req=0. On id_ready=1: entries pop in order 0x100..0x10C; imem_req reasserts the cycle after the first pop.
3. Redirect to 0x2000 while count=3 and a response is in flight -> no pop in cycle R; the stale response is not written. id_pc=0x2000 appears in R+3; no old PCs follow.
4. pc=32'hFFFF_FFF8, free-run -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
5. rst asserted while the FIFO holds 2 entries and a request is in flight -> next cycle id_valid=0, imem_req=0. After release, fetch restarts at RESET_PC with no stale entries.
6. With FETCH_MISALIGN_CHK_EN: redirect to 0x2002 -> single entry id_pc=0x2002, id_inst=0x13, id_fault=1; imem_req stays 0; a redirect to 0x3000 resumes normal fetch. Without the macro: the same stimulus fetches 0x2000.
